// File: rtl/biu_pkg.sv
// Shared types and constants for the bus-cycle sequencer.
package biu_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_T1,
      S_T2,
      S_T3,
      S_T4,
      S_HOLD
   } biu_state_e;

   // Inactive levels of the bus strobes (outside of an active phase).
   localparam logic ALE_IDLE   = 1'b0;
   localparam logic RD_N_IDLE  = 1'b1;
   localparam logic WR_N_IDLE  = 1'b1;
   localparam logic DEN_N_IDLE = 1'b1;
   localparam logic DTR_IDLE   = 1'b1;
   localparam logic IOM_IDLE   = 1'b0;

   // Number of bus beats needed to move one full CPU word.
   function automatic int unsigned biu_beats(input int unsigned data_w,
                                             input int unsigned bus_w);
      return data_w / bus_w;
   endfunction

endpackage

// File: rtl/biu_wait_timer.sv
// Counts consecutive wait states in T3 and flags when the limit is reached.
module biu_wait_timer #(
   parameter int unsigned WAIT_MAX = 0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic inc_i,
   output logic expire_o
);

   localparam int unsigned CW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   // Clear has priority; the count saturates so it can never wrap back.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // A limit of zero means wait states never abort the cycle.
   assign expire_o = (WAIT_MAX != 0) && (cnt_q == CW'(WAIT_MAX));

endmodule

// File: rtl/biu_bus_cycle.sv
// Bus-cycle sequencer: splits CPU transfers into T1-T2-T3-(TW)-T4 bus beats.
module biu_bus_cycle
   import biu_pkg::*;
#(
   parameter int unsigned ADDR_W   = 20,
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned BUS_W    = 8,
   parameter int unsigned WAIT_MAX = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic              m_io,
   input  logic              word,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] a_o,
   output logic [BUS_W-1:0]  ad_o,
   output logic              ad_oe,
   input  logic [BUS_W-1:0]  ad_i,
   output logic              ale,
   output logic              rd_n,
   output logic              wr_n,
   output logic              den_n,
   output logic              dtr,
   output logic              iom,
   input  logic              ready,
   input  logic              hold,
   output logic              hlda
);

   localparam int unsigned NB = biu_beats(DATA_W, BUS_W);
   localparam int unsigned KW = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [KW-1:0]     K_LAST = KW'(NB - 1);
   localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(BUS_W / 8);

   biu_state_e        state_q, state_d;
   logic [KW-1:0]     k_q, k_d;
   logic              abort_q, abort_d;
   logic              we_q, we_d;
   logic              m_io_q, m_io_d;
   logic              word_q, word_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [BUS_W-1:0]  wbeat;
   logic              last_beat;
   logic              wt_clr, wt_inc, wt_expire;

   biu_wait_timer #(
      .WAIT_MAX(WAIT_MAX)
   ) u_wait_timer (
      .clk_i   (clk),
      .rst_ni  (rst),
      .clr_i   (wt_clr),
      .inc_i   (wt_inc),
      .expire_o(wt_expire)
   );

   assign a_o       = addr_q + (ADDR_W'(k_q) * STEP);
   assign last_beat = !word_q || (k_q == K_LAST);
   assign rdata     = rdata_q;

   // Select the little-endian write slice for the current beat.
   always_comb begin
      wbeat = '0;
      for (int unsigned i = 0; i < NB; i++) begin
         if (k_q == KW'(i)) begin
            wbeat = wdata_q[i*BUS_W +: BUS_W];
         end
      end
   end

   // State, beat counter, capture and read-data registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         abort_q <= 1'b0;
         we_q    <= 1'b0;
         m_io_q  <= 1'b0;
         word_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         abort_q <= abort_d;
         we_q    <= we_d;
         m_io_q  <= m_io_d;
         word_q  <= word_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // Next-state logic and bus strobes for each phase of a beat.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      abort_d = abort_q;
      we_d    = we_q;
      m_io_d  = m_io_q;
      word_d  = word_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      wt_clr  = 1'b0;
      wt_inc  = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      err     = 1'b0;
      hlda    = 1'b0;
      ad_oe   = 1'b0;
      ad_o    = '0;
      ale     = ALE_IDLE;
      rd_n    = RD_N_IDLE;
      wr_n    = WR_N_IDLE;
      den_n   = DEN_N_IDLE;
      dtr     = DTR_IDLE;
      iom     = IOM_IDLE;

      unique case (state_q)
         S_IDLE: begin
            if (hold) begin
               state_d = S_HOLD;
            end else if (req) begin
               we_d    = we;
               m_io_d  = m_io;
               word_d  = word;
               addr_d  = addr;
               wdata_d = wdata;
               rdata_d = '0;
               k_d     = '0;
               abort_d = 1'b0;
               state_d = S_T1;
            end
         end
         S_T1: begin
            busy    = 1'b1;
            ale     = 1'b1;
            ad_oe   = 1'b1;
            ad_o    = a_o[BUS_W-1:0];
            dtr     = we_q;
            iom     = m_io_q;
            wt_clr  = 1'b1;
            state_d = S_T2;
         end
         S_T2, S_T3: begin
            busy  = 1'b1;
            rd_n  = we_q;
            wr_n  = !we_q;
            den_n = 1'b0;
            dtr   = we_q;
            iom   = m_io_q;
            if (we_q) begin
               ad_oe = 1'b1;
               ad_o  = wbeat;
            end
            if (state_q == S_T2) begin
               state_d = S_T3;
            end else if (ready) begin
               if (!we_q) begin
                  for (int unsigned i = 0; i < NB; i++) begin
                     if (k_q == KW'(i)) begin
                        rdata_d[i*BUS_W +: BUS_W] = ad_i;
                     end
                  end
               end
               state_d = S_T4;
            end else if (wt_expire) begin
               abort_d = 1'b1;
               state_d = S_T4;
            end else begin
               wt_inc = 1'b1;
            end
         end
         S_T4: begin
            busy = 1'b1;
            if (last_beat || abort_q) begin
               done    = 1'b1;
               err     = abort_q;
               state_d = S_IDLE;
            end else begin
               k_d     = k_q + KW'(1);
               state_d = S_T1;
            end
         end
         S_HOLD: begin
            hlda = 1'b1;
            if (!hold) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_biu_bus_cycle.sv
// Self-checking bench: an 8-bit bus instance (WAIT_MAX=3) and a 16-bit bus
// instance (no timeout), driven from shared stimulus selected by sel.
module tb_biu_bus_cycle;

   logic        clk = 1'b0;
   logic        rst;
   logic        sel;
   logic        req, we, m_io, word, ready, hold;
   logic [19:0] addr;
   logic [15:0] wdata, ad_in;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   logic        req_a, req_b, hold_a, hold_b;
   assign req_a  = req & ~sel;
   assign req_b  = req & sel;
   assign hold_a = hold & ~sel;
   assign hold_b = hold & sel;

   logic        busy_a, done_a, err_a, hlda_a, ale_a, ad_oe_a, rd_n_a, wr_n_a, den_n_a, dtr_a, iom_a;
   logic        busy_b, done_b, err_b, hlda_b, ale_b, ad_oe_b, rd_n_b, wr_n_b, den_n_b, dtr_b, iom_b;
   logic [15:0] rdata_a, rdata_b;
   logic [19:0] a_o_a, a_o_b;
   logic [7:0]  ad_o_a;
   logic [15:0] ad_o_b;

   biu_bus_cycle #(.ADDR_W(20), .DATA_W(16), .BUS_W(8), .WAIT_MAX(3)) dut_a (
      .clk(clk), .rst(rst), .req(req_a), .we(we), .m_io(m_io), .word(word),
      .addr(addr), .wdata(wdata), .busy(busy_a), .done(done_a), .err(err_a),
      .rdata(rdata_a), .a_o(a_o_a), .ad_o(ad_o_a), .ad_oe(ad_oe_a), .ad_i(ad_in[7:0]),
      .ale(ale_a), .rd_n(rd_n_a), .wr_n(wr_n_a), .den_n(den_n_a), .dtr(dtr_a),
      .iom(iom_a), .ready(ready), .hold(hold_a), .hlda(hlda_a)
   );

   biu_bus_cycle #(.ADDR_W(20), .DATA_W(16), .BUS_W(16), .WAIT_MAX(0)) dut_b (
      .clk(clk), .rst(rst), .req(req_b), .we(we), .m_io(m_io), .word(word),
      .addr(addr), .wdata(wdata), .busy(busy_b), .done(done_b), .err(err_b),
      .rdata(rdata_b), .a_o(a_o_b), .ad_o(ad_o_b), .ad_oe(ad_oe_b), .ad_i(ad_in),
      .ale(ale_b), .rd_n(rd_n_b), .wr_n(wr_n_b), .den_n(den_n_b), .dtr(dtr_b),
      .iom(iom_b), .ready(ready), .hold(hold_b), .hlda(hlda_b)
   );

   // Observed view of whichever instance is selected.
   logic [10:0] o_strb;
   logic [15:0] o_rdata, o_ad;
   logic [19:0] o_a;
   assign o_strb  = sel ? {busy_b, done_b, err_b, hlda_b, ale_b, ad_oe_b, rd_n_b, wr_n_b, den_n_b, dtr_b, iom_b}
                        : {busy_a, done_a, err_a, hlda_a, ale_a, ad_oe_a, rd_n_a, wr_n_a, den_n_a, dtr_a, iom_a};
   assign o_rdata = sel ? rdata_b : rdata_a;
   assign o_ad    = sel ? ad_o_b : {8'h00, ad_o_a};
   assign o_a     = sel ? a_o_b : a_o_a;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Expected strobe vector {busy,done,err,hlda,ale,ad_oe,rd_n,wr_n,den_n,dtr,iom} per bus phase.
   // ph: 0 idle, 1 address phase, 2 data phase (T2/T3), 4 end of beat, 5 hold.
   function automatic logic [10:0] strb(input int ph, input logic w, input logic mio,
                                        input logic dn, input logic er);
      case (ph)
         1:       return {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, w, mio};
         2:       return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, w, w, ~w, 1'b0, w, mio};
         4:       return {1'b1, dn, er, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
         5:       return {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
         default: return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      endcase
   endfunction

   // One complete transfer, starting at a falling edge with the instance idle.
   // wt0/wt1: ready-low cycles on beat 0 / later beats before ready rises.
   task automatic run_txn(input logic s, input logic w, input logic wd, input logic [19:0] a,
                          input logic [15:0] d, input logic [15:0] rp, input int wt0,
                          input int wt1, input logic hold_mid, input string tag);
      int          bw, nb, maxw, nw;
      logic [15:0] mask, beat, exp_rd;
      logic [19:0] ak;
      logic        mio, ab, r, last;
      bw     = s ? 16 : 8;
      nb     = wd ? 16 / bw : 1;
      maxw   = s ? 0 : 3;
      mask   = s ? 16'hFFFF : 16'h00FF;
      exp_rd = '0;
      ab     = 1'b0;
      mio    = 1'($urandom);
      sel = s; we = w; word = wd; addr = a; wdata = d; m_io = mio; req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      we = 1'($urandom); word = 1'($urandom); m_io = 1'($urandom);
      addr = 20'($urandom); wdata = 16'($urandom);
      for (int k = 0; k < nb; k++) begin
         ak   = a + 20'(k * (bw / 8));
         beat = (rp >> (k * bw)) & mask;
         chk({tag, "/t1_strb"}, o_strb, strb(1, w, mio, 1'b0, 1'b0));
         chk({tag, "/t1_addr"}, o_a, ak);
         chk({tag, "/t1_ad"}, o_ad, 16'(ak) & mask);
         if (k == 0) chk({tag, "/rdata_clr"}, o_rdata, 16'h0000);
         if (hold_mid && k == 0) hold = 1'b1;
         @(negedge clk);
         chk({tag, "/t2_strb"}, o_strb, strb(2, w, mio, 1'b0, 1'b0));
         if (w) chk({tag, "/t2_wdata"}, o_ad, (d >> (k * bw)) & mask);
         @(negedge clk);
         nw = (k == 0) ? wt0 : wt1;
         for (int i = 0; i < 40; i++) begin
            chk({tag, "/t3_strb"}, o_strb, strb(2, w, mio, 1'b0, 1'b0));
            r = (i >= nw);
            if (!r && maxw != 0 && i == maxw) ab = 1'b1;
            ready = r;
            ad_in = r ? beat : 16'($urandom);
            if (r && !w) exp_rd = exp_rd | (beat << (k * bw));
            @(negedge clk);
            if (r || ab) break;
         end
         ready = 1'($urandom);
         last  = (k == nb - 1);
         chk({tag, "/t4_strb"}, o_strb, strb(4, w, mio, last | ab, ab));
         @(negedge clk);
         if (ab) break;
      end
      chk({tag, "/idle_strb"}, o_strb, strb(0, 1'b0, 1'b0, 1'b0, 1'b0));
      chk({tag, "/rdata"}, o_rdata, exp_rd);
      if (hold_mid) begin
         @(negedge clk);
         chk({tag, "/hold_strb"}, o_strb, strb(5, 1'b0, 1'b0, 1'b0, 1'b0));
         hold = 1'b0;
         @(negedge clk);
         chk({tag, "/unhold_strb"}, o_strb, strb(0, 1'b0, 1'b0, 1'b0, 1'b0));
      end
   endtask

   initial begin
      rst = 1'b0; sel = 1'b0; req = 1'b0; we = 1'b0; m_io = 1'b0; word = 1'b0;
      ready = 1'b1; hold = 1'b0; addr = '0; wdata = '0; ad_in = '0;
      #12;
      chk("reset_a_strb", o_strb, strb(0, 1'b0, 1'b0, 1'b0, 1'b0));
      chk("reset_a_addr", o_a, 20'h0);
      sel = 1'b1;
      #1;
      chk("reset_b_strb", o_strb, strb(0, 1'b0, 1'b0, 1'b0, 1'b0));
      chk("reset_b_rdata", o_rdata, 16'h0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      run_txn(1'b0, 1'b0, 1'b1, 20'h12345, 16'h0000, 16'hABCD, 0, 0, 1'b0, "rd_word8");
      run_txn(1'b0, 1'b1, 1'b1, 20'hFFFFF, 16'hBEEF, 16'h0000, 2, 0, 1'b0, "wr_wrap8");
      run_txn(1'b1, 1'b0, 1'b0, 20'h0A0A1, 16'h0000, 16'h5AC3, 0, 0, 1'b0, "rd_byte16");
      run_txn(1'b1, 1'b1, 1'b1, 20'hFFFFF, 16'h1234, 16'h0000, 1, 0, 1'b0, "wr_word16");
      run_txn(1'b0, 1'b0, 1'b0, 20'h00100, 16'h0000, 16'h0077, 99, 0, 1'b0, "timeout");
      run_txn(1'b0, 1'b0, 1'b0, 20'h00101, 16'h0000, 16'h0066, 3, 0, 1'b0, "after_to");
      run_txn(1'b0, 1'b0, 1'b1, 20'h00200, 16'h0000, 16'h9F31, 0, 99, 1'b0, "abort_b1");

      // hold and req together: hold wins, then the request runs right after.
      sel = 1'b0; hold = 1'b1; req = 1'b1; we = 1'b0; word = 1'b1; addr = 20'h30000;
      @(negedge clk);
      chk("hold_req_1", o_strb, strb(5, 1'b0, 1'b0, 1'b0, 1'b0));
      @(negedge clk);
      chk("hold_req_2", o_strb, strb(5, 1'b0, 1'b0, 1'b0, 1'b0));
      hold = 1'b0;
      @(negedge clk);
      chk("hold_drop_idle", o_strb, strb(0, 1'b0, 1'b0, 1'b0, 1'b0));
      run_txn(1'b0, 1'b0, 1'b1, 20'h30000, 16'h0000, 16'h4321, 0, 1, 1'b0, "post_hold");

      run_txn(1'b1, 1'b1, 1'b1, 20'h04000, 16'hCAFE, 16'h0000, 1, 0, 1'b1, "hold_mid16");
      run_txn(1'b0, 1'b0, 1'b1, 20'h04001, 16'h0000, 16'h8E2D, 1, 2, 1'b1, "hold_mid8");

      for (int n = 0; n < 30; n++) begin
         logic s;
         s = 1'($urandom);
         run_txn(s, 1'($urandom), 1'($urandom), 20'($urandom), 16'($urandom), 16'($urandom),
                 s ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 5)),
                 s ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 5)),
                 ($urandom_range(0, 3) == 0), "rand");
      end

      // Asynchronous reset in the middle of a write wait state.
      sel = 1'b0; we = 1'b1; word = 1'b1; addr = 20'h5A5A5; wdata = 16'h3C96; m_io = 1'b1; req = 1'b1;
      @(negedge clk);
      req = 1'b0; ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_t3", o_strb, strb(2, 1'b1, 1'b1, 1'b0, 1'b0));
      #2 rst = 1'b0;
      #1;
      chk("rst_async_strb", o_strb, strb(0, 1'b0, 1'b0, 1'b0, 1'b0));
      chk("rst_async_addr", o_a, 20'h0);
      chk("rst_async_ad", o_ad, 16'h0);
      chk("rst_async_rdata", o_rdata, 16'h0);
      @(posedge clk);
      #1;
      chk("rst_hold_done", o_strb, strb(0, 1'b0, 1'b0, 1'b0, 1'b0));
      @(negedge clk);
      rst = 1'b1; ready = 1'b1;
      @(negedge clk);
      chk("rst_release_idle", o_strb, strb(0, 1'b0, 1'b0, 1'b0, 1'b0));
      run_txn(1'b0, 1'b1, 1'b0, 20'h00010, 16'h00A5, 16'h0000, 0, 0, 1'b0, "post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
